mp3_header_emitter: RTL and testbench

- Transmit-side counterpart of the byte-stream MP3 frame header parser.
- On a start pulse it latches MPEG-1 Layer III header fields and computes the frame length.
- It serialises the 32-bit header as 4 bytes, MSB first, on a valid/ready byte stream.
- It then forwards exactly frame_size−4 payload bytes from an upstream byte stream, so each emitted frame is byte-exact for the downstream parser.

---
 rtl/mp3_header_emitter.sv | 185 ++++++++++++++++++
 tb/tb_mp3_header_emitter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp3_header_emitter.sv
// MPEG-1 Layer III frame emitter: serialises a 4-byte header, then forwards
// exactly frame_size-4 payload bytes from upstream on a valid/ready byte stream.
module mp3_header_emitter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        prot,
    input  logic [3:0]  bitrate_idx,
    input  logic [1:0]  samplerate_idx,
    input  logic        padding,
    input  logic        private_bit,
    input  logic [1:0]  mode,
    input  logic [1:0]  mode_ext,
    input  logic        copyright,
    input  logic        original,
    input  logic [1:0]  emphasis,
    input  logic [7:0]  axiid,
    input  logic        axiiv,
    output logic        axiir,
    output logic [7:0]  axiod,
    output logic        axiov,
    input  logic        axior,
    output logic        busy,
    output logic [10:0] frame_size,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAYLOAD,
        DONE
    } state_t;

    state_t      state;
    logic [23:0] hdr_rest;
    logic [1:0]  byte_idx;
    logic [10:0] count;

    logic [31:0] hdr_word;
    logic [10:0] size_lut;
    logic        fields_ok;
    logic        accept;
    logic        xfer;

    assign hdr_word = {11'h7FF, 2'b11, 2'b01, prot, bitrate_idx, samplerate_idx,
                       padding, private_bit, mode, mode_ext, copyright, original,
                       emphasis};

    assign fields_ok = (bitrate_idx != 4'd0) && (bitrate_idx != 4'd15) &&
                       (samplerate_idx != 2'd3);

    // floor(144 * bitrate / samplerate) without padding, for every valid index pair
    always_comb begin
        size_lut = 11'd0;
        case ({samplerate_idx, bitrate_idx})
            // 44100 Hz
            6'h01: size_lut = 11'd104;
            6'h02: size_lut = 11'd130;
            6'h03: size_lut = 11'd156;
            6'h04: size_lut = 11'd182;
            6'h05: size_lut = 11'd208;
            6'h06: size_lut = 11'd261;
            6'h07: size_lut = 11'd313;
            6'h08: size_lut = 11'd365;
            6'h09: size_lut = 11'd417;
            6'h0A: size_lut = 11'd522;
            6'h0B: size_lut = 11'd626;
            6'h0C: size_lut = 11'd731;
            6'h0D: size_lut = 11'd835;
            6'h0E: size_lut = 11'd1044;
            // 48000 Hz
            6'h11: size_lut = 11'd96;
            6'h12: size_lut = 11'd120;
            6'h13: size_lut = 11'd144;
            6'h14: size_lut = 11'd168;
            6'h15: size_lut = 11'd192;
            6'h16: size_lut = 11'd240;
            6'h17: size_lut = 11'd288;
            6'h18: size_lut = 11'd336;
            6'h19: size_lut = 11'd384;
            6'h1A: size_lut = 11'd480;
            6'h1B: size_lut = 11'd576;
            6'h1C: size_lut = 11'd672;
            6'h1D: size_lut = 11'd768;
            6'h1E: size_lut = 11'd960;
            // 32000 Hz
            6'h21: size_lut = 11'd144;
            6'h22: size_lut = 11'd180;
            6'h23: size_lut = 11'd216;
            6'h24: size_lut = 11'd252;
            6'h25: size_lut = 11'd288;
            6'h26: size_lut = 11'd360;
            6'h27: size_lut = 11'd432;
            6'h28: size_lut = 11'd504;
            6'h29: size_lut = 11'd576;
            6'h2A: size_lut = 11'd720;
            6'h2B: size_lut = 11'd864;
            6'h2C: size_lut = 11'd1008;
            6'h2D: size_lut = 11'd1152;
            6'h2E: size_lut = 11'd1440;
            default: size_lut = 11'd0;
        endcase
    end

    // NOTE: axiir is combinational on axior so the output register can be refilled
    // on the same cycle it drains, sustaining one byte per clock.
    assign axiir  = (state == PAYLOAD) && (count != frame_size) && (!axiov || axior);
    assign accept = axiiv && axiir;
    assign xfer   = axiov && axior;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            hdr_rest   <= 24'd0;
            byte_idx   <= 2'd0;
            count      <= 11'd0;
            axiod      <= 8'd0;
            axiov      <= 1'b0;
            busy       <= 1'b0;
            frame_size <= 11'd0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (fields_ok) begin
                            frame_size <= size_lut + {10'd0, padding};
                            axiod      <= hdr_word[31:24];
                            hdr_rest   <= hdr_word[23:0];
                            byte_idx   <= 2'd0;
                            axiov      <= 1'b1;
                            busy       <= 1'b1;
                            state      <= HDR;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                HDR: begin
                    if (xfer) begin
                        if (byte_idx == 2'd3) begin
                            axiov <= 1'b0;
                            count <= 11'd4;
                            state <= PAYLOAD;
                        end else begin
                            axiod    <= hdr_rest[23:16];
                            hdr_rest <= {hdr_rest[15:0], 8'h00};
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                end

                PAYLOAD: begin
                    if (accept) begin
                        axiod <= axiid;
                        axiov <= 1'b1;
                        count <= count + 11'd1;
                    end else if (xfer) begin
                        axiov <= 1'b0;
                        // Last payload byte has left once nothing more may be accepted
                        if (count == frame_size) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    axiov <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mp3_header_emitter.sv
// Self-checking bench for mp3_header_emitter: table of frame configurations,
// hand-written stall/starve/abort sequences and randomized frames vs. a stream model.
module tb_mp3_header_emitter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        prot;
    logic [3:0]  bitrate_idx;
    logic [1:0]  samplerate_idx;
    logic        padding;
    logic        private_bit;
    logic [1:0]  mode;
    logic [1:0]  mode_ext;
    logic        copyright;
    logic        original;
    logic [1:0]  emphasis;
    logic [7:0]  axiid;
    logic        axiiv;
    logic        axiir;
    logic [7:0]  axiod;
    logic        axiov;
    logic        axior;
    logic        busy;
    logic [10:0] frame_size;
    logic        done;
    logic        err;

    mp3_header_emitter dut (
        .clk(clk), .rst(rst), .start(start), .prot(prot),
        .bitrate_idx(bitrate_idx), .samplerate_idx(samplerate_idx),
        .padding(padding), .private_bit(private_bit), .mode(mode),
        .mode_ext(mode_ext), .copyright(copyright), .original(original),
        .emphasis(emphasis), .axiid(axiid), .axiiv(axiiv), .axiir(axiir),
        .axiod(axiod), .axiov(axiov), .axior(axior), .busy(busy),
        .frame_size(frame_size), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       prot;
        logic [3:0] br;
        logic [1:0] sr;
        logic       pad;
        logic       priv;
        logic [1:0] mode;
        logic [1:0] mx;
        logic       copy;
        logic       orig;
        logic [1:0] emph;
    } fields_t;

    typedef struct {
        logic [3:0]  br;
        logic [1:0]  sr;
        logic        pad;
        logic        prot;
        int          rdy;
        bit          bad;
        int          fs;
        logic [31:0] hdr;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int last_fs = 0;
    int kbps_tab [16] = '{0, 32, 40, 48, 56, 64, 80, 96, 112, 128, 160, 192, 224, 256, 320, 0};
    int hz_tab [4] = '{44100, 48000, 32000, 1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_fs(input fields_t f);
        return (144 * 1000 * kbps_tab[f.br]) / hz_tab[f.sr] + int'(f.pad);
    endfunction

    function automatic logic [31:0] model_hdr(input fields_t f);
        return {11'h7FF, 2'b11, 2'b01, f.prot, f.br, f.sr, f.pad, f.priv,
                f.mode, f.mx, f.copy, f.orig, f.emph};
    endfunction

    function automatic fields_t rand_fields();
        fields_t f;
        f.prot = 1'($urandom_range(0, 1));
        f.br   = 4'($urandom_range(1, 14));
        f.sr   = 2'($urandom_range(0, 2));
        f.pad  = 1'($urandom_range(0, 1));
        f.priv = 1'($urandom_range(0, 1));
        f.mode = 2'($urandom_range(0, 3));
        f.mx   = 2'($urandom_range(0, 3));
        f.copy = 1'($urandom_range(0, 1));
        f.orig = 1'($urandom_range(0, 1));
        f.emph = 2'($urandom_range(0, 3));
        return f;
    endfunction

    task automatic apply_fields(input fields_t f);
        prot = f.prot; bitrate_idx = f.br; samplerate_idx = f.sr; padding = f.pad;
        private_bit = f.priv; mode = f.mode; mode_ext = f.mx; copyright = f.copy;
        original = f.orig; emphasis = f.emph;
    endtask

    // Pulse start for one cycle, then scramble the fields (don't-care afterwards)
    task automatic do_start(input fields_t f);
        @(negedge clk);
        apply_fields(f);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        apply_fields(rand_fields());
    endtask

    task automatic bad_start(input fields_t f);
        do_start(f);
        check("err_pulse", err, 1);
        check("err_busy", busy, 0);
        check("err_fs_kept", frame_size, last_fs);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("err_no_emit", axiov, 0);
        end
        check("err_one_cycle", err, 0);
    endtask

    // Run one frame. rdy: 0 always ready, 1 ready 1-of-3, 2 random.
    task automatic run_frame(input fields_t f, input int rdy, input bit vld_rand,
                             input int gap_at, input int abort_at, input bit poke,
                             output logic [31:0] obs_hdr);
        int          fs;
        logic [31:0] hdr;
        logic [7:0]  exp_q [$];
        int          sent, got, cyc, gap_left;
        logic [7:0]  prev_d;
        bit          prev_stall, acc_last, finished, aborted, chk_drain;
        fs = model_fs(f);
        hdr = model_hdr(f);
        sent = 0; got = 0; cyc = 0; gap_left = 20;
        prev_stall = 0; acc_last = 0; finished = 0; aborted = 0;
        obs_hdr = 32'd0;
        for (int i = 0; i < 4; i++) exp_q.push_back(hdr[31-8*i -: 8]);
        axiid = 8'($urandom);
        do_start(f);
        check("busy_after_start", busy, 1);
        check("frame_size", frame_size, fs);
        last_fs = fs;
        while (cyc < 20000) begin
            if (done) begin
                finished = 1;
                break;
            end
            chk_drain = 0;
            if (acc_last) axiid = 8'($urandom);
            start = poke && (cyc == 60);
            if (cyc == 60) apply_fields(rand_fields());
            case (rdy)
                0:       axior = 1'b1;
                1:       axior = (cyc % 3 == 0);
                default: axior = 1'($urandom_range(0, 1));
            endcase
            if (gap_at >= 0 && sent == gap_at && gap_left > 0) begin
                axiiv = 1'b0;
                gap_left--;
                chk_drain = (gap_left == 0);
            end else begin
                axiiv = vld_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            #1;
            if (chk_drain) check("starve_drained", axiov, 0);
            if (prev_stall) begin
                check("stall_valid_held", axiov, 1);
                check("stall_data_held", axiod, prev_d);
            end
            if (axiov && axior) begin
                if (exp_q.size() == 0) begin
                    check("extra_byte", got, fs);
                end else begin
                    check("byte", axiod, exp_q.pop_front());
                end
                if (got < 4) obs_hdr = {obs_hdr[23:0], axiod};
                got++;
            end
            acc_last = axiiv && axiir;
            if (acc_last) begin
                exp_q.push_back(axiid);
                sent++;
            end
            prev_stall = axiov && !axior;
            prev_d = axiod;
            if (abort_at >= 0 && sent == abort_at) begin
                @(posedge clk);
                #2 rst = 1'b1;
                #1;
                check("abort_axiov", axiov, 0);
                check("abort_busy", busy, 0);
                check("abort_axiir", axiir, 0);
                axiiv = 1'b0;
                start = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("abort_no_done", done, 0);
                end
                rst = 1'b0;
                last_fs = 0;
                aborted = 1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (!aborted) begin
            if (!finished) check("timeout", 0, 1);
            check("total_transfers", got, fs);
            check("payload_accepted", sent, fs - 4);
            check("queue_drained", exp_q.size(), 0);
            check("done_busy", busy, 1);
            check("done_axiov", axiov, 0);
            check("fs_kept", frame_size, fs);
            start = 1'b1;
            apply_fields(rand_fields());
            @(negedge clk);
            start = 1'b0;
            check("done_one_cycle", done, 0);
            check("busy_fell", busy, 0);
            @(negedge clk);
            check("done_start_ignored", busy, 0);
            check("idle_axiov", axiov, 0);
        end
    endtask

    vec_t        tbl [7];
    fields_t     base;
    fields_t     f;
    logic [31:0] obs;

    initial begin
        rst = 1'b1; start = 1'b0; axiiv = 1'b0; axior = 1'b0; axiid = 8'd0;
        base = '{prot: 1'b1, br: 4'd9, sr: 2'd0, pad: 1'b1, priv: 1'b0,
                 mode: 2'd1, mx: 2'd2, copy: 1'b0, orig: 1'b1, emph: 2'd0};
        apply_fields(base);

        tbl[0] = '{br: 4'd9,  sr: 2'd0, pad: 1'b1, prot: 1'b1, rdy: 0, bad: 0, fs: 418,  hdr: 32'hFFFB9264};
        tbl[1] = '{br: 4'd9,  sr: 2'd0, pad: 1'b1, prot: 1'b0, rdy: 1, bad: 0, fs: 418,  hdr: 32'hFFFA9264};
        tbl[2] = '{br: 4'd15, sr: 2'd0, pad: 1'b0, prot: 1'b1, rdy: 0, bad: 1, fs: 0,    hdr: 32'h0};
        tbl[3] = '{br: 4'd1,  sr: 2'd3, pad: 1'b0, prot: 1'b1, rdy: 0, bad: 1, fs: 0,    hdr: 32'h0};
        tbl[4] = '{br: 4'd14, sr: 2'd2, pad: 1'b1, prot: 1'b1, rdy: 2, bad: 0, fs: 1441, hdr: 32'hFFFBEA64};
        tbl[5] = '{br: 4'd1,  sr: 2'd1, pad: 1'b0, prot: 1'b1, rdy: 0, bad: 0, fs: 96,   hdr: 32'hFFFB1464};
        tbl[6] = '{br: 4'd0,  sr: 2'd0, pad: 1'b0, prot: 1'b1, rdy: 0, bad: 1, fs: 0,    hdr: 32'h0};

        #12;
        check("rst_axiov", axiov, 0);
        check("rst_axiod", axiod, 0);
        check("rst_axiir", axiir, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_fs", frame_size, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            f = base;
            f.br = tbl[i].br; f.sr = tbl[i].sr; f.pad = tbl[i].pad; f.prot = tbl[i].prot;
            if (tbl[i].bad) begin
                bad_start(f);
            end else begin
                run_frame(f, tbl[i].rdy, 1'b0, -1, -1, 1'b0, obs);
                check("tbl_header", obs, tbl[i].hdr);
                check("tbl_frame_size", frame_size, tbl[i].fs);
            end
        end

        // Upstream starvation mid-payload plus a start pulsed while busy
        run_frame(rand_fields(), 0, 1'b0, 50, -1, 1'b1, obs);

        // Reset at payload byte 100, then a fresh frame
        run_frame(base, 0, 1'b0, -1, 100, 1'b0, obs);
        f = rand_fields();
        run_frame(f, 0, 1'b0, -1, -1, 1'b0, obs);
        check("post_reset_header", obs, model_hdr(f));

        for (int i = 0; i < 4; i++) begin
            run_frame(rand_fields(), 2, 1'b1, -1, -1, 1'b0, obs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
